io_seq: RTL

//  Sequences the INPUT (OP=4'hE) and OUTPUT (OP=4'hF) instructions of the Nano core against

---
 rtl/nano_pkg.sv | 28 ++
 rtl/io_seq_if.sv | 22 ++
 rtl/io_fifo.sv | 62 ++++++
 rtl/io_seq.sv | 138 +++++++++++++
 4 files changed

// File: rtl/nano_pkg.sv
// Opcode table and io_seq state encodings, shared between the Nano control unit and io_seq.
package nano_pkg;

    localparam logic [3:0] opNOP    = 4'h0;
    localparam logic [3:0] opADD    = 4'h1;
    localparam logic [3:0] opSUB    = 4'h2;
    localparam logic [3:0] opAND    = 4'h3;
    localparam logic [3:0] opOR     = 4'h4;
    localparam logic [3:0] opXOR    = 4'h5;
    localparam logic [3:0] opNOT    = 4'h6;
    localparam logic [3:0] opSHL    = 4'h7;
    localparam logic [3:0] opSHR    = 4'h8;
    localparam logic [3:0] opLDI    = 4'h9;
    localparam logic [3:0] opLD     = 4'hA;
    localparam logic [3:0] opST     = 4'hB;
    localparam logic [3:0] opJMP    = 4'hC;
    localparam logic [3:0] opBZ     = 4'hD;
    localparam logic [3:0] opINPUT  = 4'hE;
    localparam logic [3:0] opOUTPUT = 4'hF;

    typedef enum logic [1:0] {
        IO_IDLE     = 2'd0,
        IO_IN_WAIT  = 2'd1,
        IO_IN_WR    = 2'd2,
        IO_OUT_WAIT = 2'd3
    } io_state_e;

endpackage

// File: rtl/io_seq_if.sv
// External ready/valid ports of io_seq: one input stream and one output stream.
interface io_seq_if #(parameter int DATA_W = 8);

    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;

    // master is the io_seq side; slave is the external producer/sink
    modport master (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid
    );

    modport slave (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid
    );

endinterface

// File: rtl/io_fifo.sv
// Small output FIFO with a combinational head; full-FIFO push is legal when a pop happens in the same cycle.
module io_fifo #(
    parameter int DATA_W    = 8,
    parameter int OUT_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] head,
    output logic              full,
    output logic              empty
);

    localparam int AW = $clog2(OUT_DEPTH);

    logic [AW-1:0]     wr_ptr_reg;
    logic [AW-1:0]     rd_ptr_reg;
    logic [AW:0]       count_reg;
    logic [DATA_W-1:0] entry_q [OUT_DEPTH];
    logic              do_push;
    logic              do_pop;

    assign full    = (count_reg == (AW+1)'(OUT_DEPTH));
    assign empty   = (count_reg == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign head    = empty ? '0 : entry_q[rd_ptr_reg];

    genvar gi;
    generate
        for (gi = 0; gi < OUT_DEPTH; gi++) begin : g_entry
            logic [DATA_W-1:0] entry_reg;
            always_ff @(posedge clk or negedge rst) begin
                if (!rst)
                    entry_reg <= '0;
                else if (do_push && (wr_ptr_reg == AW'(gi)))
                    entry_reg <= din;
            end
            assign entry_q[gi] = entry_reg;
        end
    endgenerate

    // Power-of-two depth lets the pointers wrap naturally.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/io_seq.sv
// Sequences Nano INPUT/OUTPUT instructions: timed wait for input data, FIFO-buffered output.
module io_seq
    import nano_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int OUT_DEPTH = 4,
    parameter int TIMEOUT   = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [3:0]        OP,
    input  logic [DATA_W-1:0] RegData,
    io_seq_if.master          io,
    output logic              Stall,
    output logic              WrIO,
    output logic [DATA_W-1:0] WrData,
    output logic              Done,
    output logic              TimeoutErr,
    input  logic              err_clr
);

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    io_state_e         state_reg;
    logic [7:0]        cnt_reg;
    logic [DATA_W-1:0] wr_data_reg;
    logic [DATA_W-1:0] out_word_reg;
    logic              wr_io_reg;
    logic              done_reg;
    logic              err_reg;

    logic              is_in;
    logic              is_out;
    logic              fifo_full;
    logic              fifo_empty;
    logic              pop;
    logic              push_ok;
    logic              fifo_push;
    logic [DATA_W-1:0] fifo_din;

    assign is_in   = start & (OP == opINPUT);
    assign is_out  = start & (OP == opOUTPUT);
    assign pop     = ~fifo_empty & io.out_ready;
    assign push_ok = ~fifo_full | pop;

    always_comb begin
        fifo_push = 1'b0;
        fifo_din  = RegData;
        if (state_reg == IO_IDLE && is_out && push_ok) begin
            fifo_push = 1'b1;
        end else if (state_reg == IO_OUT_WAIT && push_ok) begin
            fifo_push = 1'b1;
            fifo_din  = out_word_reg;
        end
    end

    io_fifo #(
        .DATA_W    (DATA_W),
        .OUT_DEPTH (OUT_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (pop),
        .din   (fifo_din),
        .head  (io.out_data),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign io.out_valid = ~fifo_empty;
    assign io.in_ready  = (state_reg == IO_IN_WAIT);
    assign Stall        = (state_reg != IO_IDLE) | is_in | (is_out & ~push_ok);
    assign WrIO         = wr_io_reg;
    assign WrData       = wr_data_reg;
    assign Done         = done_reg;
    assign TimeoutErr   = err_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= IO_IDLE;
            cnt_reg      <= '0;
            wr_data_reg  <= '0;
            out_word_reg <= '0;
            wr_io_reg    <= 1'b0;
            done_reg     <= 1'b0;
            err_reg      <= 1'b0;
        end else begin
            wr_io_reg <= 1'b0;
            done_reg  <= 1'b0;
            // A timeout later in this block overrides the clear.
            if (err_clr) err_reg <= 1'b0;
            case (state_reg)
                IO_IDLE: begin
                    if (is_in) begin
                        state_reg <= IO_IN_WAIT;
                        cnt_reg   <= '0;
                    end else if (is_out) begin
                        if (push_ok) begin
                            done_reg <= 1'b1;
                        end else begin
                            state_reg    <= IO_OUT_WAIT;
                            out_word_reg <= RegData;
                        end
                    end
                end
                IO_IN_WAIT: begin
                    if (io.in_valid) begin
                        wr_data_reg <= io.in_data;
                        wr_io_reg   <= 1'b1;
                        done_reg    <= 1'b1;
                        state_reg   <= IO_IN_WR;
                    end else if (cnt_reg == TO_LAST) begin
                        wr_data_reg <= '0;
                        err_reg     <= 1'b1;
                        wr_io_reg   <= 1'b1;
                        done_reg    <= 1'b1;
                        state_reg   <= IO_IN_WR;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                IO_IN_WR: begin
                    state_reg <= IO_IDLE;
                end
                IO_OUT_WAIT: begin
                    if (push_ok) begin
                        done_reg  <= 1'b1;
                        state_reg <= IO_IDLE;
                    end
                end
                default: state_reg <= IO_IDLE;
            endcase
        end
    end

endmodule
